// File: rtl/noc_arb_pkg.sv
// Shared arbitration types and the round-robin pick used by the tile's NoC arbiters.
// Purely declarative: no clocked logic, no latency.
// No backpressure of its own; callers gate the pick with their own accept condition.
package noc_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Widest requester vector rr_next can handle; callers zero-extend into it.
    localparam int unsigned ARB_MAX_REQ = 16;
    localparam int unsigned ARB_IDX_W   = $clog2(ARB_MAX_REQ);

    // One-hot grant of the first asserted req bit searching ptr+1, ptr+2, ...
    // (mod num_req). Returns all zeros when no request is pending.
    function automatic logic [ARB_MAX_REQ-1:0] rr_next(
        input logic [ARB_MAX_REQ-1:0] req,
        input int unsigned            ptr,
        input int unsigned            num_req
    );
        logic [ARB_MAX_REQ-1:0] gnt;
        logic                   found;
        logic [ARB_IDX_W-1:0]   idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= ARB_MAX_REQ; i++) begin
            idx = ARB_IDX_W'((ptr + i) % num_req);
            if ((i <= num_req) && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker: one-hot grant of the first requester after ptr.
// Latency: 0 cycles (pure combinational).
// No backpressure: the caller decides whether the grant is actually consumed.
//   req : request vector, one bit per requester
//   ptr : index of the most recently served requester (lowest priority next)
//   gnt : one-hot winner, zero when req is zero
module noc_rr_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt
);

    logic [ARB_MAX_REQ-1:0] req_ext;
    logic [ARB_MAX_REQ-1:0] gnt_ext;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        gnt_ext              = rr_next(req_ext, 32'(ptr), NUM_REQ);
        gnt                  = gnt_ext[NUM_REQ-1:0];
    end

    // Bits above NUM_REQ are never granted because they are never requested.
    if (NUM_REQ < ARB_MAX_REQ) begin : g_unused_hi
        logic unused_gnt_hi;
        assign unused_gnt_hi = |gnt_ext[ARB_MAX_REQ-1:NUM_REQ];
    end

endmodule

// File: rtl/noc_tx_pkt_arbiter.sv
// Packet-granular round-robin mux of NUM_REQ flit sources onto one NoC output channel.
// Latency: 1 cycle from input transfer to out_valid; sustains 1 flit/cycle.
// Backpressure: out_ready=0 with a flit held stalls everything (in_ready all 0, output stable).
//   in_flit/in_last/in_valid/in_ready : per-requester flit streams (valid&ready = transfer)
//   out_flit/out_last/out_valid/out_ready : registered output channel
//   grant : one-hot owner of the packet in progress, 0 when idle
//   pkt_len_err : single-cycle pulse alongside a flit that was cut at MAX_PKT_LEN
module noc_tx_pkt_arbiter
    import noc_arb_pkg::*;
#(
    parameter int unsigned FLIT_WIDTH  = 32,
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned MAX_PKT_LEN = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0][FLIT_WIDTH-1:0] in_flit,
    input  logic [NUM_REQ-1:0]                 in_last,
    input  logic [NUM_REQ-1:0]                 in_valid,
    output logic [NUM_REQ-1:0]                 in_ready,
    output logic [FLIT_WIDTH-1:0]              out_flit,
    output logic                               out_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NUM_REQ-1:0]                 grant,
    output logic                               pkt_len_err
);

    localparam int unsigned      PTR_W     = $clog2(NUM_REQ);
    localparam int unsigned      CNT_W     = $clog2(MAX_PKT_LEN + 1);
    // Count of flits already accepted when the next non-last flit must be cut.
    localparam logic [CNT_W-1:0] CNT_TRUNC = CNT_W'(MAX_PKT_LEN - 1);
    // Pointing at the highest index makes requester 0 the first winner.
    localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);

    arb_state_t            state_q,       state_d;
    logic [NUM_REQ-1:0]    grant_q,       grant_d;
    logic [PTR_W-1:0]      rr_ptr_q,      rr_ptr_d;
    logic [CNT_W-1:0]      flit_cnt_q,    flit_cnt_d;
    logic [FLIT_WIDTH-1:0] out_flit_q,    out_flit_d;
    logic                  out_last_q,    out_last_d;
    logic                  out_valid_q,   out_valid_d;
    logic                  pkt_len_err_q, pkt_len_err_d;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [NUM_REQ-1:0]    rdy;
    logic [NUM_REQ-1:0]    xfer;
    logic                  can_acc;
    logic                  acc;
    logic                  trunc;
    logic                  pkt_end;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic                  sel_last;
    logic [PTR_W-1:0]      owner_idx;

    noc_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req (in_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    // Handshake and flit selection.
    always_comb begin
        // The output register can take a new flit if it is empty or draining now.
        can_acc = ~out_valid_q | out_ready;

        if (state_q == ARB_IDLE) begin
            rdy = arb_gnt & {NUM_REQ{can_acc}};
        end else begin
            rdy = grant_q & {NUM_REQ{can_acc}};
        end

        // Never accept while reset is asserted, even combinationally.
        in_ready = rst_n ? rdy : '0;
        xfer     = in_ready & in_valid;
        acc      = |xfer;

        // xfer is at most one-hot, so a priority loop is a plain mux.
        sel_flit  = '0;
        sel_last  = 1'b0;
        owner_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (xfer[i]) begin
                sel_flit  = in_flit[i];
                sel_last  = in_last[i];
                owner_idx = PTR_W'(i);
            end
        end

        // flit_cnt is 0 in IDLE, so MAX_PKT_LEN=1 cuts every non-last flit at once.
        trunc   = acc & ~sel_last & (flit_cnt_q == CNT_TRUNC);
        pkt_end = acc & (sel_last | trunc);
    end

    // Next-state: packet lock, length counter, pointer and output register.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        flit_cnt_d    = flit_cnt_q;
        out_flit_d    = out_flit_q;
        out_last_d    = out_last_q;
        out_valid_d   = out_valid_q;
        pkt_len_err_d = trunc;

        if (acc) begin
            out_flit_d  = sel_flit;
            out_last_d  = sel_last | trunc;
            out_valid_d = 1'b1;
            if (pkt_end) begin
                // A cut packet's tail re-arbitrates behind the other requesters.
                state_d    = ARB_IDLE;
                grant_d    = '0;
                flit_cnt_d = '0;
                rr_ptr_d   = owner_idx;
            end else begin
                state_d    = ARB_LOCKED;
                grant_d    = xfer;
                flit_cnt_d = flit_cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= PTR_RST;
            flit_cnt_q    <= '0;
            out_flit_q    <= '0;
            out_last_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            pkt_len_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            flit_cnt_q    <= flit_cnt_d;
            out_flit_q    <= out_flit_d;
            out_last_q    <= out_last_d;
            out_valid_q   <= out_valid_d;
            pkt_len_err_q <= pkt_len_err_d;
        end
    end

    assign out_flit    = out_flit_q;
    assign out_last    = out_last_q;
    assign out_valid   = out_valid_q;
    assign grant       = grant_q;
    assign pkt_len_err = pkt_len_err_q;

endmodule

// File: tb/tb_noc_tx_pkt_arbiter.sv
// Randomized bench for noc_tx_pkt_arbiter with a packet-level reference model.
// Sources are preloaded with packet queues; the model predicts the output stream order.
// out_ready and mid-packet source gaps are randomized; neither may change the order.
module tb_noc_tx_pkt_arbiter;

    localparam int FW    = 32;
    localparam int NR    = 3;
    localparam int MAXL  = 4;
    localparam int DEPTH = 64;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NR-1:0][FW-1:0]  in_flit;
    logic [NR-1:0]          in_last;
    logic [NR-1:0]          in_valid;
    logic [NR-1:0]          in_ready;
    logic [FW-1:0]          out_flit;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [NR-1:0]          grant;
    logic                   pkt_len_err;

    noc_tx_pkt_arbiter #(
        .FLIT_WIDTH  (FW),
        .NUM_REQ     (NR),
        .MAX_PKT_LEN (MAXL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_flit     (in_flit),
        .in_last     (in_last),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_flit    (out_flit),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .grant       (grant),
        .pkt_len_err (pkt_len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [FW-1:0] flit;
        logic          last;
        logic          err;
        logic [1:0]    src;
    } exp_t;

    exp_t          exp_q[$];
    logic [FW-1:0] src_flit  [NR][DEPTH];
    bit            src_last  [NR][DEPTH];
    bit            src_start [NR][DEPTH];
    int            src_len   [NR];
    int            pos       [NR];
    int            model_ptr;
    int            n_chk;
    int            n_fail;
    int            seq;
    bit            gap_en;
    bit            stall_en;
    logic          prev_vld;
    logic          prev_hs;
    logic [FW-1:0] prev_flit;
    logic          prev_last;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Fill the selected sources with packets; mark which flits open an arbitrated segment.
    task automatic load_sources(input logic [NR-1:0] which, input int max_pkts,
                                input int min_plen, input int max_plen);
        int npk;
        int plen;
        int k;
        for (int s = 0; s < NR; s++) begin
            src_len[s] = 0;
            pos[s]     = 0;
            if (which[s]) begin
                npk = $urandom_range(max_pkts, 1);
                for (int p = 0; p < npk; p++) begin
                    plen = $urandom_range(max_plen, min_plen);
                    for (int j = 0; j < plen; j++) begin
                        src_flit[s][src_len[s]] = {2'(s), 14'(seq), 16'($urandom)};
                        src_last[s][src_len[s]] = (j == plen - 1);
                        seq++;
                        src_len[s]++;
                    end
                end
            end
            k = 0;
            for (int j = 0; j < src_len[s]; j++) begin
                src_start[s][j] = (k == 0);
                k++;
                if (src_last[s][j] || k == MAXL) k = 0;
            end
        end
    endtask

    // Packet-level round robin: each segment (cut at MAXL flits) goes out whole.
    task automatic build_model();
        int   p [NR];
        int   s;
        int   cand;
        int   k;
        bit   found;
        bit   l;
        exp_t e;
        for (int i = 0; i < NR; i++) p[i] = pos[i];
        while (1) begin
            found = 0;
            s     = 0;
            for (int i = 1; i <= NR; i++) begin
                cand = (model_ptr + i) % NR;
                if (!found && p[cand] < src_len[cand]) begin
                    s     = cand;
                    found = 1;
                end
            end
            if (!found) break;
            k = 0;
            do begin
                l      = src_last[s][p[s]];
                k++;
                e.flit = src_flit[s][p[s]];
                e.last = l || (k == MAXL);
                e.err  = !l && (k == MAXL);
                e.src  = 2'(s);
                exp_q.push_back(e);
                p[s]++;
            end while (!(l || k == MAXL) && p[s] < src_len[s]);
            model_ptr = s;
        end
    endtask

    task automatic drive_inputs();
        for (int s = 0; s < NR; s++) begin
            if (pos[s] < src_len[s]) begin
                in_flit[s]  = src_flit[s][pos[s]];
                in_last[s]  = src_last[s][pos[s]];
                // Only the lock owner may go quiet mid-segment without changing the order.
                if (!gap_en || src_start[s][pos[s]]) in_valid[s] = 1'b1;
                else                                 in_valid[s] = ($urandom_range(3, 0) != 0);
            end else begin
                in_flit[s]  = '0;
                in_last[s]  = 1'b0;
                in_valid[s] = 1'b0;
            end
        end
        out_ready = stall_en ? ($urandom_range(2, 0) != 0) : 1'b1;
    endtask

    task automatic sample_check(output bit nf);
        exp_t e;
        nf = out_valid && (!prev_vld || prev_hs);
        check_eq("rdy_onehot", 64'($onehot0(in_ready)), 64'(1));
        if (out_valid && !out_ready) check_eq("rdy_stall", 64'(in_ready), 64'(0));
        if (nf) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_flit", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check_eq("flit",    64'(out_flit),    64'(e.flit));
                check_eq("last",    64'(out_last),    64'(e.last));
                check_eq("len_err", 64'(pkt_len_err), 64'(e.err));
                check_eq("grant",   64'(grant),       e.last ? 64'(0) : (64'(1) << e.src));
            end
        end else begin
            check_eq("len_err_quiet", 64'(pkt_len_err), 64'(0));
            if (out_valid) begin
                check_eq("hold_flit", 64'(out_flit), 64'(prev_flit));
                check_eq("hold_last", 64'(out_last), 64'(prev_last));
            end
        end
        prev_hs   = out_valid & out_ready;
        prev_vld  = out_valid;
        prev_flit = out_flit;
        prev_last = out_last;
    endtask

    // Entered and left at posedge+1.
    task automatic run_phase(input bit g, input bit st, input bit tput);
        int            cyc;
        int            bubbles;
        bit            started;
        bit            nf;
        logic [NR-1:0] xf;
        gap_en   = g;
        stall_en = st;
        build_model();
        drive_inputs();
        cyc     = 0;
        bubbles = 0;
        started = 0;
        while (exp_q.size() > 0 && cyc < 4000) begin
            @(negedge clk);
            sample_check(nf);
            if (tput) begin
                if (nf) started = 1;
                else if (started && exp_q.size() > 0) bubbles++;
            end
            xf = in_valid & in_ready;
            @(posedge clk);
            #1;
            for (int s = 0; s < NR; s++) if (xf[s]) pos[s]++;
            drive_inputs();
            cyc++;
        end
        check_eq("phase_drained", 64'(exp_q.size()), 64'(0));
        if (tput) check_eq("bubbles", 64'(bubbles), 64'(0));
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        seq       = 0;
        model_ptr = NR - 1;
        prev_vld  = 1'b0;
        prev_hs   = 1'b0;
        prev_flit = '0;
        prev_last = 1'b0;
        gap_en    = 0;
        stall_en  = 0;
        for (int s = 0; s < NR; s++) begin
            src_len[s] = 0;
            pos[s]     = 0;
        end
        rst_n     = 1'b0;
        in_valid  = '1;
        in_last   = '0;
        in_flit   = '0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 64'(out_valid),   64'(0));
        check_eq("rst_out_flit",  64'(out_flit),    64'(0));
        check_eq("rst_out_last",  64'(out_last),    64'(0));
        check_eq("rst_grant",     64'(grant),       64'(0));
        check_eq("rst_len_err",   64'(pkt_len_err), 64'(0));
        check_eq("rst_in_ready",  64'(in_ready),    64'(0));

        load_sources(3'b111, 4, 1, 6);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full-rate drain: ordering plus no bubbles across packet boundaries.
        run_phase(0, 0, 1);

        // Single-flit packets from everyone: strict 0,1,2 rotation, grant stays 0.
        load_sources(3'b111, 3, 1, 1);
        run_phase(0, 0, 1);

        // Random subsets with output stalls and owner gaps.
        for (int r = 0; r < 8; r++) begin
            load_sources(3'($urandom_range(7, 1)), 4, 1, 7);
            run_phase(1, 1, 0);
        end

        // Reset in the middle of a locked packet from requester 1.
        load_sources(3'b010, 1, 3, 3);
        gap_en   = 0;
        stall_en = 0;
        drive_inputs();
        @(posedge clk);
        #1;
        pos[1]++;
        drive_inputs();
        #2;
        check_eq("pre_rst_valid", 64'(out_valid), 64'(1));
        check_eq("pre_rst_grant", 64'(grant),     64'(3'b010));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid",    64'(out_valid),   64'(0));
        check_eq("mid_rst_grant",    64'(grant),       64'(0));
        check_eq("mid_rst_in_ready", 64'(in_ready),    64'(0));
        check_eq("mid_rst_last",     64'(out_last),    64'(0));
        check_eq("mid_rst_len_err",  64'(pkt_len_err), 64'(0));
        for (int s = 0; s < NR; s++) src_len[s] = 0;
        drive_inputs();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        prev_vld  = 1'b0;
        prev_hs   = 1'b0;
        model_ptr = NR - 1;

        // After reset requester 0 must win first and length counting starts afresh.
        load_sources(3'b111, 4, 1, 7);
        run_phase(1, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
